// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: state encoding and default sizing shared by uart_tx_sched and rr_pick.
package uart_sched_pkg;
   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_ISSUE       = 2'd1;
   localparam logic [1:0] ST_WAIT_ACCEPT = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE   = 2'd3;
   localparam int DEF_NUM_REQ        = 2;
   localparam int DEF_TIMEOUT_CYCLES = 131072;
   function automatic int id_width(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap.
module rr_pick import uart_sched_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int GW = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      ptr,
   output logic [GW-1:0]      gnt_id,
   output logic               any
);
   logic [GW-1:0] idx;
   // Scan farthest-first so the closest request to ptr is the last write.
   always_comb begin
      gnt_id = '0;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = GW'((int'(ptr) + i) % NUM_REQ);
         gnt_id = req[idx] ? idx : gnt_id;
      end
   end
   assign any = |req;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one 8N1 UART tx engine between NUM_REQ byte producers.
// Define UART_TX_SCHED_TIMEOUT_EN to abort frames that exceed TIMEOUT_CYCLES and flag err.
module uart_tx_sched import uart_sched_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int GW = id_width(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [7:0]           tx_byte,
   output logic                 tx_send,
   input  logic                 tx_done,
   output logic                 busy,
   output logic [GW-1:0]        grant_id,
   output logic                 err
);
   logic [1:0]    state, state_nx;
   logic [GW-1:0] rr_ptr, pick;
   logic          any, cap, rel, timeout;
   logic [7:0]    req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[8*g +: 8];
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .gnt_id (pick),
      .any    (any)
   );

   // The tx_done gate in IDLE keeps us off an engine still busy from before a reset or abort.
   assign cap = state == ST_IDLE && any && tx_done;
   assign rel = (state == ST_WAIT_DONE && tx_done) || timeout;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn)
         state <= ST_IDLE;
      else
         state <= state_nx;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         tx_byte  <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         if (cap) begin
            tx_byte  <= req_bytes[pick];
            grant_id <= pick;
         end
         if (rel)
            rr_ptr <= grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end

   always_comb begin
      state_nx = timeout                  ? ST_IDLE :
                 state == ST_IDLE         ? (cap ? ST_ISSUE : ST_IDLE) :
                 state == ST_ISSUE        ? ST_WAIT_ACCEPT :
                 state == ST_WAIT_ACCEPT  ? (tx_done ? ST_WAIT_ACCEPT : ST_WAIT_DONE) :
                                            (tx_done ? ST_IDLE : ST_WAIT_DONE);
   end

   always_comb begin
      tx_send = state == ST_ISSUE;
      busy    = state != ST_IDLE;
      req_ack = state == ST_ISSUE ? NUM_REQ'(1) << grant_id : '0;
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] cnt;
   logic          waiting;
   assign waiting = state == ST_WAIT_ACCEPT || state == ST_WAIT_DONE;
   // cnt counts clocks since ISSUE began; abort on the edge where it would reach the limit.
   assign timeout = waiting && cnt == TW'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= state == ST_ISSUE ? TW'(1) : waiting ? cnt + 1'b1 : cnt;
         if (timeout)
            err <= 1'b1;
      end
`else
   assign timeout = 1'b0;
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed plus randomized checks of uart_tx_sched against a queue-based arbitration model.
module tb_uart_tx_sched;
   localparam int N = 3;
   typedef struct packed {logic [7:0] b; logic [1:0] g; logic [2:0] a;} ev_t;

   logic clk = 0, resetn = 1, hold_low = 1, tx_done;
   logic [N-1:0] req_valid = '0, req_ack;
   logic [8*N-1:0] req_data = '0;
   logic [7:0] tx_byte;
   logic tx_send, busy, err;
   logic [1:0] grant_id;
   int tests = 0, fails = 0, overlap = 0, bad_ack = 0, eng_left = 0, eng_len = 10, mptr = 0;
   logic [7:0] src [N][$];
   ev_t ev_q[$], exp_q[$], mon_e;

   always #5 clk = ~clk;

   uart_tx_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
      .req_ack(req_ack), .tx_byte(tx_byte), .tx_send(tx_send), .tx_done(tx_done),
      .busy(busy), .grant_id(grant_id), .err(err)
   );

   // Engine model: txdone drops the clock after senddata and stays low eng_len clocks.
   assign tx_done = !(eng_left != 0 || hold_low);
   always @(posedge clk) eng_left <= eng_left != 0 ? eng_left - 1 : tx_send ? eng_len : 0;

   // Monitor and requesters: each requester presents its queue head until acked.
   always @(negedge clk) begin
      if (tx_send) begin
         mon_e = {tx_byte, grant_id, req_ack};
         ev_q.push_back(mon_e);
         if (eng_left != 0) overlap++;
      end
      if (req_ack != 0 && !tx_send) bad_ack++;
      for (int i = 0; i < N; i++) begin
         if (req_ack[i] && src[i].size() > 0) void'(src[i].pop_front());
         req_valid[i] = src[i].size() > 0;
         req_data[8*i +: 8] = src[i].size() > 0 ? src[i][0] : 8'h00;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit src_empty();
      for (int i = 0; i < N; i++) if (src[i].size() != 0) return 0;
      return 1;
   endfunction

   // Reference: serve nonempty requesters in round-robin order from mptr, one byte per grant.
   task automatic predict();
      logic [7:0] m [N][$];
      int w, left;
      bit found;
      ev_t e;
      left = 0;
      for (int i = 0; i < N; i++) begin m[i] = src[i]; left += src[i].size(); end
      while (left > 0) begin
         found = 0; w = 0;
         for (int k = 0; k < N; k++)
            if (!found && m[(mptr + k) % N].size() > 0) begin w = (mptr + k) % N; found = 1; end
         e.b = m[w].pop_front(); e.g = 2'(w); e.a = 3'(1 << w);
         exp_q.push_back(e);
         mptr = (w + 1) % N;
         left--;
      end
   endtask

   task automatic settle(input string tag, input int budget);
      int k = 0;
      while (k < budget && !(src_empty() && !busy && tx_done)) begin @(negedge clk); #1; k++; end
      check({tag, "_settle"}, k < budget, 1);
   endtask

   task automatic check_events(input string tag);
      check({tag, "_count"}, ev_q.size(), exp_q.size());
      for (int k = 0; k < ev_q.size() && k < exp_q.size(); k++) begin
         check({tag, "_byte"}, ev_q[k].b, exp_q[k].b);
         check({tag, "_gid"},  ev_q[k].g, exp_q[k].g);
         check({tag, "_ack"},  ev_q[k].a, exp_q[k].a);
      end
      ev_q.delete(); exp_q.delete();
   endtask

   task automatic reset_pulse(input string tag);
      resetn = 0;
      #1;
      check({tag, "_tx_send"}, tx_send, 0);
      check({tag, "_tx_byte"}, tx_byte, 0);
      check({tag, "_req_ack"}, req_ack, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_grant_id"}, grant_id, 0);
      check({tag, "_err"}, err, 0);
      mptr = 0;
      @(negedge clk);
      resetn = 1;
   endtask

   initial begin
      #1;
      reset_pulse("reset");
      // Engine reports busy after reset: requester 1 must wait for tx_done.
      src[1].push_back(8'h6D); predict();
      repeat (20) begin @(negedge clk); #1; end
      check("gate_no_send", ev_q.size(), 0);
      hold_low = 0;
      for (int k = 0; k < 2 && ev_q.size() == 0; k++) begin @(negedge clk); #1; end
      check("gate_issue", ev_q.size(), 1);
      settle("gate", 200); check_events("gate");

      reset_pulse("reset2");
      eng_len = 12;
      src[0].push_back(8'hA0); src[0].push_back(8'hA0);
      src[1].push_back(8'hB1); src[1].push_back(8'hB1);
      predict(); settle("alt", 400); check_events("alt");

      eng_len = 20;
      src[0].push_back(8'h55); predict();
      for (int k = 0; k < 50 && ev_q.size() == 0; k++) begin @(negedge clk); #1; end
      for (int k = 0; k < 50 && tx_done; k++) begin @(negedge clk); #1; end
      check("single_busy_mid", busy, 1);
      for (int k = 0; k < 50 && !tx_done; k++) begin @(negedge clk); #1; end
      check("single_busy_last", busy, 1);
      @(negedge clk); #1;
      check("single_busy_clear", busy, 0);
      check_events("single");

      src[0].push_back(8'h0F); src[2].push_back(8'hF2);
      predict(); settle("wrap", 300); check_events("wrap");

      for (int r = 0; r < 6; r++) begin
         eng_len = $urandom_range(3, 14);
         for (int i = 0; i < N; i++) repeat ($urandom_range(0, 2)) src[i].push_back(8'($urandom));
         predict(); settle("rand", 1000); check_events("rand");
      end

      eng_len = 40;
      src[0].push_back(8'h3C); predict();
      for (int k = 0; k < 50 && ev_q.size() == 0; k++) begin @(negedge clk); #1; end
      repeat (5) begin @(negedge clk); #1; end
      check("midframe_busy", busy, 1);
      reset_pulse("midframe");
      src[1].push_back(8'hC3); predict();
      for (int k = 0; k < 100 && !tx_done; k++) begin @(negedge clk); #1; end
      check("midframe_held", ev_q.size(), 1);
      settle("midframe", 200); check_events("midframe");

`ifdef UART_TX_SCHED_TIMEOUT_EN
      eng_len = 5;
      src[0].push_back(8'h99); predict();
      for (int k = 0; k < 50 && ev_q.size() == 0; k++) begin @(negedge clk); #1; end
      hold_low = 1;
      repeat (15) begin @(negedge clk); #1; end
      check("to_busy_before", busy, 1);
      check("to_err_before", err, 0);
      @(negedge clk); #1;
      check("to_busy_after", busy, 0);
      check("to_err_after", err, 1);
      src[1].push_back(8'h11); predict();
      repeat (10) begin @(negedge clk); #1; end
      check("to_hold", ev_q.size(), 1);
      hold_low = 0;
      settle("timeout", 200); check_events("timeout");
      check("to_err_sticky", err, 1);
`endif

      check("overlap", overlap, 0);
      check("bad_ack", bad_ack, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one 8N1 UART transmit engine (`uart_tx_8n1`) between `NUM_REQ` byte producers, e.g. the CPU MMIO console port and the debug monitor. It sits between the requesters and the engine. It captures one byte at a time from the winning requester and drives the engine's `senddata`/`txbyte` inputs. It then tracks `txdone` through the frame before granting the next requester.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 1..8.
- `TIMEOUT_CYCLES`, 131072: clock cycles allowed per frame before abort. Used only with the timeout feature.

Ports:
- `clk` in 1: system clock, single clock domain.
- `resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester byte available; level signal.
- `req_data` in 8*NUM_REQ: per-requester byte; requester i uses bits [8i+7:8i].
- `req_ack` out NUM_REQ: one-hot, one-cycle pulse when requester i's byte is captured.
- `tx_byte` out 8: byte to engine `txbyte`.
- `tx_send` out 1: one-cycle pulse to engine `senddata`.
- `tx_done` in 1: engine `txdone`; low while a frame is in flight, high when idle or complete.
- `busy` out 1: high from capture until frame completion or abort.
- `grant_id` out clog2(NUM_REQ), min 1: index of the last captured requester.
- `err` out 1: sticky timeout flag. Tied 0 when the timeout feature is compiled out.

## Operation
- States: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE.
- Reset values:
  - state IDLE.
  - `tx_send`=0, `tx_byte`=0, `req_ack`=0, `busy`=0, `grant_id`=0, `err`=0.
  - Round-robin pointer `rr_ptr`=0.
- IDLE:
  - Transition requires any `req_valid` AND `tx_done`=1.
  - Winner = first set `req_valid` searching from `rr_ptr` upward, with wrap to 0.
  - On transition: latch winner's byte into `tx_byte`, set `grant_id`=winner, go to ISSUE.
  - If `tx_done`=0, stay in IDLE. This covers an engine still sending after reset.
- ISSUE (1 cycle):
  - `tx_send`=1, `req_ack[grant_id]`=1, `busy`=1.
  - Next state WAIT_ACCEPT.
- WAIT_ACCEPT:
  - Hold until `tx_done`=0, then go to WAIT_DONE.
- WAIT_DONE:
  - Hold until `tx_done`=1.
  - Then: `busy`=0, `rr_ptr`=(`grant_id`+1) mod NUM_REQ, go to IDLE.
- `tx_byte` holds its value from capture until the next capture.
- Requester protocol:
  - Keep `req_valid` and data stable until `req_ack`.
  - In the cycle after `req_ack`, either drop `req_valid` or present the next byte.
  - There is no double capture, because the FSM is not in IDLE on the `req_ack` cycle.
- `req_valid` changes while not in IDLE are ignored until IDLE is re-entered.
- Single active requester: it is served back-to-back, and the pointer still advances.
- `resetn` asserted mid-frame:
  - All state is cleared immediately and the in-flight byte is dropped, with no `req_ack` re-issue.
  - The engine is not reset by this block. The IDLE `tx_done` gate prevents a new issue until the engine finishes.

## Timing
- From capture (IDLE with a valid request) to `tx_send`/`req_ack`: 1 clk. Both are registered outputs.
- Minimum spacing between two `tx_send` pulses: one full engine frame (10 baud periods) plus 2 clk.
- `tx_done` is sampled directly.
  - The engine lowers `txdone` on the clk after `senddata`, so WAIT_ACCEPT normally lasts 1 clk.
  - The engine raises `txdone` at the stop-bit baud tick.
- Arbitration is fair: with all requesters continuously valid, each is served once every NUM_REQ frames.

## Configuration
- Macro: `UART_TX_SCHED_TIMEOUT_EN`.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on ISSUE and increments in WAIT_ACCEPT and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, set `err`=1 (sticky until reset), clear `busy`, and advance `rr_ptr` past `grant_id`.
  - The IDLE `tx_done` gate still applies after an abort.
- Undefined:
  - No counter. WAIT_ACCEPT and WAIT_DONE wait indefinitely, and `err` is constant 0.

## Structure
- Package `uart_sched_pkg`:
  - State encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT_ACCEPT=2'd2, ST_WAIT_DONE=2'd3.
  - Default NUM_REQ and TIMEOUT_CYCLES constants.
- Sub-module `rr_pick`:
  - Combinational round-robin picker with inputs `req`[NUM_REQ] and `ptr`.
  - Outputs `gnt_id` and `any`.

## Test plan
- Single requester 0 with byte 0x55 and an engine model: exactly one `tx_send` with `tx_byte`=0x55, `req_ack[0]` in the same cycle, `busy` high until `tx_done` rises, then IDLE.
- Requesters 0 and 1 both continuously valid with bytes 0xA0 and 0xB1: issue order 0xA0, 0xB1, 0xA0, 0xB1, and `grant_id` alternates 0, 1, 0, 1.
- `tx_done` held low after reset while `req_valid[1]`=1: no `tx_send` until `tx_done`=1, then issue within 2 clk.
- Drop `resetn` during WAIT_DONE: all outputs return to reset values asynchronously, and after release no issue occurs while `tx_done`=0.
- Timeout, with TIMEOUT_EN defined, TIMEOUT_CYCLES=16, and `tx_done` stuck low after issue: `err`=1 and `busy`=0 at 16 clk after ISSUE, and the next request is held until `tx_done`=1.
- With NUM_REQ=3, requests on 0 and 2 only, and pointer at 1: requester 2 wins first, then requester 0.
